// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requesting datapath and serial_adder_ctrl.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, c_in,
                  input  ready, busy, done, sum, c_out, ovf);
  modport slave  (input  start, a, b, c_in,
                  output ready, busy, done, sum, c_out, ovf);
`else
  modport master (output start, a, b, c_in,
                  input  ready, busy, done, sum, c_out);
  modport slave  (input  start, a, b, c_in,
                  output ready, busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one gate-level full-adder slice walks WIDTH bits LSB first.
// Optional macro SERIAL_ADD_OVF_EN enables the registered signed-overflow flag.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int                CNT_W  = $clog2(WIDTH) + 1;
  localparam int                WORK_W = WIDTH - 1;
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WORK_W-1:0]  work;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               c_out_q;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;
  logic               ready_d;
  logic               busy_d;
  logic               done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q;
`endif

  // The shared full-adder slice, kept at gate level.
  always_comb begin
    fa_sum  = a_sr[0] ^ b_sr[0] ^ carry;
    fa_cout = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  end

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_d     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sum bits enter at the top of work, so after WIDTH-1 shifts the final slice
  // output completes the result as {fa_sum, work}; sum only changes on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      work    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= fa_cout;
          work  <= WORK_W'({fa_sum, work} >> 1);
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum_q   <= {fa_sum, work};
            c_out_q <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= carry ^ fa_cout;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready = ready_d;
  assign bus.busy  = busy_d;
  assign bus.done  = done_d;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic model.
// Define SERIAL_ADD_OVF_EN for both files to also check the overflow flag.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 9-bit addition and signed-range test.
  function automatic logic [W:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv);
    int s;
    s = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    return (s > 127) || (s < -128);
  endfunction

  function automatic logic get_ovf();
`ifdef SERIAL_ADD_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one add; operands are scrambled right after acceptance.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output int busy_n, output bit tmo, output bit held_ok,
                         output bit one_pulse);
    logic [W-1:0] prev_s;
    logic         prev_c;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.c_in  = cv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.c_in  = 1'($urandom);
    prev_s  = bus.sum;
    prev_c  = bus.c_out;
    busy_n  = 0;
    tmo     = 1'b1;
    held_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        tmo = 1'b0;
        break;
      end
      if (bus.busy) busy_n++;
      if (bus.sum !== prev_s || bus.c_out !== prev_c) held_ok = 1'b0;
      @(posedge clk); #1;
    end
    s  = bus.sum;
    co = bus.c_out;
    ov = get_ovf();
    @(posedge clk); #1;
    one_pulse = (bus.done === 1'b0) && (bus.ready === 1'b1);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got rbd=%b want 100", {bus.ready, bus.busy, bus.done});
    end
    n_cmp++;
    if (bus.sum !== '0 || bus.c_out !== 1'b0 || get_ovf() !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_result: got sum=%h c=%b ovf=%b want 00/0/0",
               bus.sum, bus.c_out, get_ovf());
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Checks one add end to end against the model.
  task automatic check_add(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv);
    logic [W-1:0] s;
    logic         co, ov;
    int           bn;
    bit           tmo, held, pulse;
    logic [W:0]   exp;
    run_add(av, bv, cv, s, co, ov, bn, tmo, held, pulse);
    exp = ref_add(av, bv, cv);
    n_cmp++;
    if (tmo) begin
      n_err++;
      $display("[TB] FAIL %s_timeout: got no done within 40 cycles want done", name);
      return;
    end
    n_cmp++;
    if ({co, s} !== exp) begin
      n_err++;
      $display("[TB] FAIL %s_result: a=%h b=%h c_in=%b got c_out=%b sum=%h want c_out=%b sum=%h",
               name, av, bv, cv, co, s, exp[W], exp[W-1:0]);
    end
    n_cmp++;
    if (bn !== W) begin
      n_err++;
      $display("[TB] FAIL %s_busy_len: got %0d want %0d", name, bn, W);
    end
    n_cmp++;
    if (!held || !pulse) begin
      n_err++;
      $display("[TB] FAIL %s_timing: got held=%0d one_pulse=%0d want 1/1", name, held, pulse);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_cmp++;
    if (ov !== ref_ovf(av, bv, cv)) begin
      n_err++;
      $display("[TB] FAIL %s_ovf: a=%h b=%h got %b want %b", name, av, bv, ov, ref_ovf(av, bv, cv));
    end
`endif
  endtask

  task automatic test_directed();
    check_add("dir_5a_33", 8'h5A, 8'h33, 1'b0);
    check_add("dir_ff_01", 8'hFF, 8'h01, 1'b0);
    check_add("dir_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
    check_add("dir_7f_01", 8'h7F, 8'h01, 1'b0);
    check_add("dir_80_80", 8'h80, 8'h80, 1'b0);
    check_add("dir_10_20", 8'h10, 8'h20, 1'b0);
    check_add("dir_00_00", 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      check_add("rand", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  // Start pulses and new operands while busy and while done must not disturb the add.
  task automatic test_ignore_start();
    logic [W-1:0] av, bv, prev_s;
    logic [W:0]   exp;
    bit           seen;
    av  = W'($urandom);
    bv  = W'($urandom);
    exp = ref_add(av, bv, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.c_in  = 1'b1;
    @(posedge clk); #1;
    prev_s = bus.sum;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.start = 1'($urandom);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.c_in  = 1'($urandom);
      @(posedge clk); #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      n_cmp++;
      if (bus.sum !== prev_s) begin
        n_err++;
        $display("[TB] FAIL ign_partial: got sum=%h during run want %h", bus.sum, prev_s);
      end
    end
    n_cmp++;
    if (!seen || {bus.c_out, bus.sum} !== exp) begin
      n_err++;
      $display("[TB] FAIL ign_result: got seen=%0d c_out=%b sum=%h want 1 c_out=%b sum=%h",
               seen, bus.c_out, bus.sum, exp[W], exp[W-1:0]);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ign_done_start: got ready=%b busy=%b want 1/0", bus.ready, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    bit got_done;
    check_add("pre_rst", 8'hC3, 8'h5A, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.c_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.sum !== '0 || bus.c_out !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midrst_state: got rbd=%b sum=%h c=%b want 100/00/0",
               {bus.ready, bus.busy, bus.done}, bus.sum, bus.c_out);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    got_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) got_done = 1'b1;
    end
    n_cmp++;
    if (got_done) begin
      n_err++;
      $display("[TB] FAIL midrst_no_done: got done pulse after abort want none");
    end
    check_add("post_rst", 8'h12, 8'h34, 1'b0);
  endtask

  task automatic test_start_held();
    int last_t, n_done, bad_gap, bad_sum;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.c_in  = 1'b0;
    last_t  = -1;
    n_done  = 0;
    bad_gap = 0;
    bad_sum = 0;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (last_t >= 0 && (t - last_t) != W + 2) bad_gap++;
        if (bus.sum !== 8'h02 || bus.c_out !== 1'b0) bad_sum++;
        last_t = t;
        n_done++;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (n_done != 3 || bad_gap != 0) begin
      n_err++;
      $display("[TB] FAIL held_rate: got dones=%0d bad_gaps=%0d want 3/0", n_done, bad_gap);
    end
    n_cmp++;
    if (bad_sum != 0) begin
      n_err++;
      $display("[TB] FAIL held_sum: got %0d wrong results want 0", bad_sum);
    end
    for (int i = 0; i < 20 && bus.ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL held_idle: got ready=%b want 1", bus.ready);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_start_held();
    check_add("final", 8'hA5, 8'h5A, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
